// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch stage.
// Widths, PC step, fetch FSM states and queue entry layout.
package if_pkg;

    localparam int XLEN   = 64;
    localparam int INST_W = 32;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_fifo2.sv
// Two-entry fetch queue with registered head.
// Flush dominates push and pop in the same cycle.
module if_fifo2
    import if_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output logic         head_valid,
    output fetch_entry_t head
);

    logic [1:0]   cnt_q;
    fetch_entry_t e0_q;
    fetch_entry_t e1_q;
    logic         do_pop;

    assign do_pop     = pop && (cnt_q != 2'd0);
    assign count      = cnt_q;
    assign head_valid = (cnt_q != 2'd0);
    assign head       = e0_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 2'd0;
            e0_q  <= '0;
            e1_q  <= '0;
        end else if (flush) begin
            cnt_q <= 2'd0;
        end else begin
            unique case (1'b1)
                (do_pop && push): begin
                    if (cnt_q == 2'd2) begin
                        e0_q <= e1_q;
                        e1_q <= push_data;
                    end else begin
                        e0_q <= push_data;
                    end
                end
                (do_pop && !push): begin
                    e0_q  <= e1_q;
                    cnt_q <= cnt_q - 2'd1;
                end
                (!do_pop && push): begin
                    if (cnt_q == 2'd0) begin
                        e0_q <= push_data;
                    end else begin
                        e1_q <= push_data;
                    end
                    cnt_q <= cnt_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: one outstanding imem request,
// next-PC generation and a 2-entry queue to decode.
module if_fetch_unit #(
    parameter int XLEN       = 64,
    parameter int INST_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   inst_addr,
    output logic [XLEN-1:0]   next_pc,
    output logic              pc_en,
    input  logic              redirect,
    input  logic [XLEN-1:0]   redirect_target,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              out_valid,
    output logic [INST_W-1:0] out_inst,
    output logic [XLEN-1:0]   out_pc,
    input  logic              out_ready
);
    import if_pkg::*;

    localparam logic [1:0] FULL = 2'(FIFO_DEPTH);

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic [XLEN-1:0] req_pc_q;
    logic            hs;
    logic            push;
    logic [1:0]      count;
    fetch_entry_t    push_data;
    fetch_entry_t    head;

    assign imem_addr = {inst_addr[XLEN-1:2], 2'b00};
    assign hs        = imem_req && imem_ready;
    assign push      = (state_q == WAIT) && imem_rvalid;
    assign push_data = '{pc: req_pc_q, inst: imem_rdata};
    assign out_pc    = head.pc;
    assign out_inst  = head.inst;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            req_pc_q <= '0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                req_pc_q <= inst_addr;
            end
        end
    end

    // A response landing with the redirect is simply flushed.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (hs) state_d = WAIT;
            WAIT: begin
                if (imem_rvalid) begin
                    state_d = IDLE;
                end else if (redirect) begin
                    state_d = DROP;
                end
            end
            DROP: if (imem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        pc_en    = 1'b0;
        next_pc  = '0;
        if (reset) begin
            imem_req = (state_q == IDLE) && !redirect
                       && (count < FULL);
            pc_en    = redirect || (imem_req && imem_ready);
            next_pc  = redirect ? redirect_target
                                : inst_addr + XLEN'(PC_STEP);
        end
    end

    if_fifo2 u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (out_ready),
        .flush     (redirect),
        .count     (count),
        .head_valid(out_valid),
        .head      (head)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a PC register
// and 1-cycle instruction memory modelled around it.
module tb_if_fetch_unit;

    logic        clk;
    logic        reset;
    logic [63:0] inst_addr;
    logic [63:0] next_pc;
    logic        pc_en;
    logic        redirect;
    logic [63:0] redirect_target;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [63:0] out_pc;
    logic        out_ready;

    int n_chk;
    int n_fail;

    logic        auto_pc;
    logic        auto_mem;
    logic [63:0] hs_addr[$];
    logic [63:0] pop_pc[$];
    logic [31:0] pop_inst[$];

    typedef struct {
        logic [63:0] addr;
        logic        redir;
        logic [63:0] tgt;
        logic        rdy;
        logic [63:0] e_iaddr;
        logic [63:0] e_npc;
        logic        e_req;
        logic        e_pcen;
    } vec_t;

    vec_t vecs[5];

    if_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .inst_addr      (inst_addr),
        .next_pc        (next_pc),
        .pc_en          (pc_en),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_ready      (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [63:0] a);
        return 32'hC000_0000 ^ a[31:0];
    endfunction

    task automatic chk(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h",
                     name, got, exp);
        end
    endtask

    // Negedge to negedge; environment reacts after the edge.
    task automatic step();
        logic        s_hs;
        logic        s_pcen;
        logic        s_pop;
        logic [63:0] s_npc;
        logic [63:0] s_addr;
        #1;
        s_hs   = imem_req & imem_ready;
        s_pcen = pc_en;
        s_npc  = next_pc;
        s_addr = imem_addr;
        s_pop  = out_valid & out_ready;
        if (s_hs) hs_addr.push_back(s_addr);
        if (s_pop) begin
            pop_pc.push_back(out_pc);
            pop_inst.push_back(out_inst);
        end
        @(posedge clk);
        #1;
        if (auto_pc && s_pcen) inst_addr = s_npc;
        if (auto_mem) begin
            imem_rvalid = s_hs;
            imem_rdata  = s_hs ? memf(s_addr) : 32'h0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [63:0] pc0,
                            input logic ordy);
        reset       = 1'b0;
        redirect    = 1'b0;
        imem_rvalid = 1'b0;
        imem_ready  = 1'b1;
        auto_pc     = 1'b1;
        auto_mem    = 1'b1;
        out_ready   = ordy;
        step();
        inst_addr = pc0;
        reset     = 1'b1;
        hs_addr.delete();
        pop_pc.delete();
        pop_inst.delete();
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        vecs[0] = '{64'h6, 1'b0, 64'h0, 1'b1,
                    64'h4, 64'hA, 1'b1, 1'b1};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0, 1'b1,
                    64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1'b1, 1'b1};
        vecs[2] = '{64'h10, 1'b0, 64'h0, 1'b0,
                    64'h10, 64'h14, 1'b1, 1'b0};
        vecs[3] = '{64'h20, 1'b1, 64'h100, 1'b1,
                    64'h20, 64'h100, 1'b0, 1'b1};
        vecs[4] = '{64'h13, 1'b0, 64'h0, 1'b0,
                    64'h10, 64'h17, 1'b1, 1'b0};

        reset           = 1'b0;
        inst_addr       = 64'h0;
        redirect        = 1'b1;
        redirect_target = 64'h300;
        imem_ready      = 1'b1;
        imem_rvalid     = 1'b0;
        imem_rdata      = 32'h0;
        out_ready       = 1'b1;
        auto_pc         = 1'b0;
        auto_mem        = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_req", imem_req, 1'b0);
        chk("rst_pcen", pc_en, 1'b0);
        chk("rst_npc", next_pc, 64'h0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_pc", out_pc, 64'h0);
        chk("rst_inst", out_inst, 32'h0);

        // Combinational vectors in IDLE with an empty queue.
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            inst_addr       = vecs[i].addr;
            redirect        = vecs[i].redir;
            redirect_target = vecs[i].tgt;
            imem_ready      = vecs[i].rdy;
            #1;
            chk($sformatf("v%0d_iaddr", i), imem_addr,
                vecs[i].e_iaddr);
            chk($sformatf("v%0d_npc", i), next_pc,
                vecs[i].e_npc);
            chk($sformatf("v%0d_req", i), imem_req,
                vecs[i].e_req);
            chk($sformatf("v%0d_pcen", i), pc_en,
                vecs[i].e_pcen);
        end
        @(negedge clk);

        // Sequential fetch from 0 with 1-cycle memory.
        do_reset(64'h0, 1'b1);
        step();
        chk("s1_valid_n1", out_valid, 1'b0);
        chk("s1_pc_n1", inst_addr, 64'h4);
        step();
        chk("s1_valid_n2", out_valid, 1'b1);
        chk("s1_head_pc", out_pc, 64'h0);
        chk("s1_head_inst", out_inst, memf(64'h0));
        for (int i = 0; i < 20 && pop_pc.size() < 3; i++) step();
        chk("s1_npop", 64'(pop_pc.size() >= 3), 64'h1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("s1_pop%0d_pc", i), pop_pc[i],
                64'(4 * i));
            chk($sformatf("s1_pop%0d_inst", i), pop_inst[i],
                memf(64'(4 * i)));
            chk($sformatf("s1_hs%0d", i), hs_addr[i],
                64'(4 * i));
        end

        // Decode stalled: queue fills, fetch stops.
        do_reset(64'h0, 1'b0);
        for (int i = 0; i < 10; i++) step();
        chk("s2_nhs", 64'(hs_addr.size()), 64'd2);
        chk("s2_req", imem_req, 1'b0);
        chk("s2_pcen", pc_en, 1'b0);
        chk("s2_pc", inst_addr, 64'h8);
        chk("s2_head", out_pc, 64'h0);
        out_ready = 1'b1;
        for (int i = 0; i < 12 && pop_pc.size() < 3; i++) step();
        chk("s2_hs3", hs_addr[2], 64'h8);
        chk("s2_pop1", pop_pc[1], 64'h4);
        chk("s2_pop2", pop_pc[2], 64'h8);

        // Memory not ready for 3 cycles at 0x10.
        do_reset(64'h10, 1'b1);
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("s3_addr%0d", i), imem_addr, 64'h10);
            chk($sformatf("s3_pc%0d", i), inst_addr, 64'h10);
            chk($sformatf("s3_valid%0d", i), out_valid, 1'b0);
        end
        imem_ready = 1'b1;
        step();
        chk("s3_pc_go", inst_addr, 64'h14);

        // Redirect while waiting on 0x20.
        do_reset(64'h1C, 1'b0);
        step();
        step();
        step();
        auto_mem    = 1'b0;
        imem_rvalid = 1'b0;
        chk("s4_valid", out_valid, 1'b1);
        chk("s4_wait_req", imem_req, 1'b0);
        redirect        = 1'b1;
        redirect_target = 64'h100;
        #1;
        chk("s4_pcen", pc_en, 1'b1);
        chk("s4_npc", next_pc, 64'h100);
        step();
        redirect = 1'b0;
        #1;
        chk("s4_flush", out_valid, 1'b0);
        chk("s4_drop_req", imem_req, 1'b0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        #1;
        chk("s4_dropped", out_valid, 1'b0);
        chk("s4_req", imem_req, 1'b1);
        chk("s4_addr", imem_addr, 64'h100);
        auto_mem  = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        chk("s4_out_valid", out_valid, 1'b1);
        chk("s4_out_pc", out_pc, 64'h100);
        chk("s4_out_inst", out_inst, memf(64'h100));

        // Redirect together with a pop and a push.
        do_reset(64'h40, 1'b0);
        step();
        step();
        step();
        chk("s5_pre_valid", out_valid, 1'b1);
        chk("s5_pre_rv", imem_rvalid, 1'b1);
        out_ready       = 1'b1;
        redirect        = 1'b1;
        redirect_target = 64'h200;
        step();
        redirect = 1'b0;
        #1;
        chk("s5_valid", out_valid, 1'b0);
        chk("s5_req", imem_req, 1'b1);
        chk("s5_addr", imem_addr, 64'h200);

        // Stray response in IDLE is ignored.
        auto_mem    = 1'b0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        step();
        imem_rvalid = 1'b0;
        #1;
        chk("s6_valid", out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
